// File: rtl/mem_ctrl_fsm.sv
// Sequencing controller for the 16-bit external memory port: fixed-phase read/write
// bus sequences with acknowledge wait, timeout abort and read-data capture.
module mem_ctrl_fsm #(
   parameter int ADDR_W      = 10,
   parameter int INIT_CYCLES = 16,
   parameter int TIMEOUT     = 255
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rd_req,
   input  logic              i_wr_req,
   input  logic              i_done_clr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [15:0]       i_req_wdata,
   input  logic [15:0]       i_mem_rdata,
   input  logic              i_mem_ack,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   output logic              o_mem_cs,
   output logic              o_mem_oe,
   output logic              o_mem_we,
   output logic [12:0]       o_state,
   output logic [15:0]       o_rd_data,
   output logic              o_busy,
   output logic              o_err
);

   localparam logic [12:0] S_RESET   = 13'h0001;
   localparam logic [12:0] S_IDLE    = 13'h0002;
   localparam logic [12:0] S_RD_ST0  = 13'h0004;
   localparam logic [12:0] S_RD_ST1  = 13'h0008;
   localparam logic [12:0] S_RD_ST2  = 13'h0010;
   localparam logic [12:0] S_RD_WAIT = 13'h0020;
   localparam logic [12:0] S_RD_DONE = 13'h0040;
   localparam logic [12:0] S_WR_ST0  = 13'h0080;
   localparam logic [12:0] S_WR_ST1  = 13'h0100;
   localparam logic [12:0] S_WR_ST2  = 13'h0200;
   localparam logic [12:0] S_WR_ST3  = 13'h0400;
   localparam logic [12:0] S_WR_ST4  = 13'h0800;
   localparam logic [12:0] S_WR_WAIT = 13'h1000;

   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   logic [12:0]       r_state;
   logic [7:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wdata;
   logic [15:0]       r_rd_data;
   logic              r_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_RESET;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_RESET: begin
               if (r_cnt == INIT_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            // Read has priority; a simultaneous write is dropped, not queued.
            S_IDLE: begin
               if (i_rd_req)      r_state <= S_RD_ST0;
               else if (i_wr_req) r_state <= S_WR_ST0;
            end
            S_RD_ST0: begin
               r_addr  <= i_req_addr;
               r_state <= S_RD_ST1;
            end
            S_RD_ST1: r_state <= S_RD_ST2;
            S_RD_ST2: begin
               r_cnt   <= '0;
               r_state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (i_mem_ack) begin
                  r_rd_data <= i_mem_rdata;
                  r_err     <= 1'b0;
                  r_state   <= S_RD_DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RD_DONE: if (i_done_clr) r_state <= S_IDLE;
            S_WR_ST0: begin
               r_addr  <= i_req_addr;
               r_wdata <= i_req_wdata;
               r_state <= S_WR_ST1;
            end
            S_WR_ST1: r_state <= S_WR_ST2;
            S_WR_ST2: r_state <= S_WR_ST3;
            S_WR_ST3: r_state <= S_WR_ST4;
            S_WR_ST4: begin
               r_cnt   <= '0;
               r_state <= S_WR_WAIT;
            end
            S_WR_WAIT: begin
               if (i_mem_ack) begin
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_cnt == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            // Corrupted (non-one-hot) state falls back to IDLE.
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from the state register only, so a corrupted value keeps the bus idle.
   logic w_cs, w_oe, w_we;
   always_comb begin
      w_cs = 1'b0;
      w_oe = 1'b0;
      w_we = 1'b0;
      case (r_state)
         S_RD_ST1:               w_cs = 1'b1;
         S_RD_ST2, S_RD_WAIT:    begin w_cs = 1'b1; w_oe = 1'b1; end
         S_WR_ST1, S_WR_ST2:     w_cs = 1'b1;
         S_WR_ST3, S_WR_ST4:     begin w_cs = 1'b1; w_we = 1'b1; end
         S_WR_WAIT:              w_cs = 1'b1;
         default:                ;
      endcase
   end

   assign o_mem_cs    = w_cs;
   assign o_mem_oe    = w_oe;
   assign o_mem_we    = w_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_state     = r_state;
   assign o_rd_data   = r_rd_data;
   assign o_err       = r_err;
   assign o_busy      = (r_state != S_IDLE) && (r_state != S_RD_DONE);

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Randomized bench for mem_ctrl_fsm: each transaction is expanded into its expected
// per-cycle state list from the phase rules and every output is compared per cycle.
module tb_mem_ctrl_fsm;

   localparam int AW   = 10;
   localparam int INIT = 16;
   localparam int TO   = 8;

   localparam logic [12:0] S_RST   = 13'h0001;
   localparam logic [12:0] S_IDLE  = 13'h0002;
   localparam logic [12:0] S_RST0  = 13'h0004;
   localparam logic [12:0] S_RST1  = 13'h0008;
   localparam logic [12:0] S_RST2  = 13'h0010;
   localparam logic [12:0] S_RWAIT = 13'h0020;
   localparam logic [12:0] S_DONE  = 13'h0040;
   localparam logic [12:0] S_WST0  = 13'h0080;
   localparam logic [12:0] S_WST1  = 13'h0100;
   localparam logic [12:0] S_WST2  = 13'h0200;
   localparam logic [12:0] S_WST3  = 13'h0400;
   localparam logic [12:0] S_WST4  = 13'h0800;
   localparam logic [12:0] S_WWAIT = 13'h1000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_req = 1'b0, wr_req = 1'b0, done_clr = 1'b0, mem_ack = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [15:0]   req_wdata = '0, mem_rdata = '0;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, rd_data;
   logic          mem_cs, mem_oe, mem_we, busy, err;
   logic [12:0]   state;

   mem_ctrl_fsm #(.ADDR_W(AW), .INIT_CYCLES(INIT), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .i_wr_req(wr_req),
      .i_done_clr(done_clr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_cs(mem_cs), .o_mem_oe(mem_oe), .o_mem_we(mem_we),
      .o_state(state), .o_rd_data(rd_data), .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [AW-1:0] addr_m;
   logic [15:0]   wdata_m, rd_m;
   logic          err_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected {cs,oe,we} for each phase of the bus sequence.
   function automatic logic [2:0] bus_of(input logic [12:0] s);
      if (s == S_RST1 || s == S_WST1 || s == S_WST2 || s == S_WWAIT) return 3'b100;
      if (s == S_RST2 || s == S_RWAIT) return 3'b110;
      if (s == S_WST3 || s == S_WST4) return 3'b101;
      return 3'b000;
   endfunction

   task automatic check_outs(input logic [12:0] es);
      chk("state", 32'(state), 32'(es));
      chk("bus", 32'({mem_cs, mem_oe, mem_we}), 32'(bus_of(es)));
      chk("busy", 32'(busy), 32'(es != S_IDLE && es != S_DONE));
      chk("addr", 32'(mem_addr), 32'(addr_m));
      chk("wdata", 32'(mem_wdata), 32'(wdata_m));
      chk("rdata", 32'(rd_data), 32'(rd_m));
      chk("err", 32'(err), 32'(err_m));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rd_req = 0; wr_req = 0; done_clr = 0; mem_ack = 0;
      addr_m = '0; wdata_m = '0; rd_m = '0; err_m = 1'b0;
      @(negedge clk);
      check_outs(S_RST);
      rst_n = 1'b1;
      repeat (INIT - 1) begin
         @(negedge clk);
         check_outs(S_RST);
      end
      @(negedge clk);
      check_outs(S_IDLE);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check_outs(S_IDLE);
         mem_ack = 1'($urandom); done_clr = 1'($urandom); mem_rdata = 16'($urandom);
      end
   endtask

   // Called at a negedge with the DUT in IDLE. dly = index of the WAIT cycle carrying ack
   // (>= TO means never), clr = READ_DONE cycles before done_clr, abort_at = list index
   // at which reset is asserted (-1 for none).
   task automatic txn(input bit is_rd, input bit both, input logic [AW-1:0] a,
                      input logic [15:0] wd, input logic [15:0] rdat,
                      input int dly, input int clr, input int abort_at);
      logic [12:0] q[$];
      bit acked;
      int w, wi, di;
      acked = dly < TO;
      w = acked ? dly + 1 : TO;
      if (is_rd) begin
         q = '{S_RST0, S_RST1, S_RST2};
         repeat (w) q.push_back(S_RWAIT);
         if (acked) repeat (clr + 1) q.push_back(S_DONE);
      end else begin
         q = '{S_WST0, S_WST1, S_WST2, S_WST3, S_WST4};
         repeat (w) q.push_back(S_WWAIT);
      end
      q.push_back(S_IDLE);
      rd_req = is_rd; wr_req = !is_rd || both;
      req_addr = a; req_wdata = wd;
      mem_ack = 1'($urandom); done_clr = 1'($urandom);
      wi = 0; di = 0;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         check_outs(q[i]);
         if (i == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_we", 32'(mem_we), 32'(0));
            chk("rst_cs", 32'(mem_cs), 32'(0));
            chk("rst_state", 32'(state), 32'(S_RST));
            return;
         end
         if (i == 0) begin
            addr_m = a;
            if (!is_rd) wdata_m = wd;
         end else begin
            req_addr = AW'($urandom); req_wdata = 16'($urandom);
         end
         rd_req = 1'($urandom); wr_req = 1'($urandom);
         done_clr = 1'($urandom); mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
         if (q[i] == S_IDLE) begin
            rd_req = 0; wr_req = 0;
         end
         if (q[i] == S_RWAIT || q[i] == S_WWAIT) begin
            mem_ack = (wi == dly);
            if (mem_ack) begin
               mem_rdata = rdat;
               if (is_rd) rd_m = rdat;
               err_m = 1'b0;
            end else if (wi == w - 1) begin
               err_m = 1'b1;
            end
            wi++;
         end
         if (q[i] == S_DONE) begin
            done_clr = (di == clr);
            di++;
         end
      end
   endtask

   initial begin
      do_reset();
      txn(1, 0, 10'h05A, 16'h0000, 16'hBEEF, 2, 1, -1);
      txn(0, 0, 10'h3FF, 16'h1234, 16'h0000, 0, 0, -1);
      txn(1, 0, 10'h155, 16'h0000, 16'hAAAA, 100, 0, -1);
      txn(0, 0, 10'h0A5, 16'h5678, 16'h0000, 0, 0, -1);
      txn(0, 0, 10'h200, 16'h9999, 16'h0000, 100, 0, -1);
      txn(1, 1, 10'h123, 16'hDEAD, 16'hC0DE, 0, 0, -1);
      idle(2);
      txn(0, 0, 10'h111, 16'h2222, 16'h0000, 0, 0, 3);
      do_reset();
      for (int n = 0; n < 60; n++) begin
         idle(int'($urandom_range(0, 3)));
         txn(1'($urandom), 1'($urandom), AW'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)), -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_fsm.md
# mem_ctrl_fsm

Sequencing controller for the board's 16-bit external memory port. It accepts single-cycle read/write requests from the switch/button front end, runs a fixed multi-phase bus sequence with an acknowledge wait and timeout, and captures read data. It exports a 13-bit one-hot state vector and the captured word, which feed the downstream six-digit HEX display decoder.

## Interface
- ADDR_W, 10: memory address width.
- INIT_CYCLES, 16: cycles spent in RESET after reset release; legal range 1..255.
- TIMEOUT, 255: maximum cycles spent in a WAIT state before abort; legal range 1..255.

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  single-cycle read request, synchronous to clk.
- wr_req  in  1  single-cycle write request, synchronous to clk.
- done_clr  in  1  single-cycle pulse; releases READ_DONE.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  16  write data.
- mem_rdata  in  16  memory read data; valid while mem_ack=1.
- mem_ack  in  1  memory acknowledge.
- mem_addr  out  ADDR_W  registered bus address.
- mem_wdata  out  16  registered bus write data.
- mem_cs  out  1  chip select.
- mem_oe  out  1  output enable (read).
- mem_we  out  1  write enable.
- state  out  13  one-hot state: bit0 RESET, 1 IDLE, 2 READ_ST0, 3 READ_ST1, 4 READ_ST2, 5 READ_WAIT, 6 READ_DONE, 7 WRITE_ST0, 8 WRITE_ST1, 9 WRITE_ST2, 10 WRITE_ST3, 11 WRITE_ST4, 12 WRITE_WAIT.
- rd_data  out  16  last captured read word.
- busy  out  1  high in every state except IDLE and READ_DONE.
- err  out  1  sticky timeout flag.

## Operation
- Reset asserted (asynchronously, including mid-operation): state=RESET (13'h0001), cycle counter=0, mem_cs/mem_oe/mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, err=0, busy=1.
- RESET: counter increments each cycle; on counter==INIT_CYCLES-1 go to IDLE and clear counter.
- IDLE: rd_req=1 -> READ_ST0; else wr_req=1 -> WRITE_ST0. Read wins when both are high; the write is dropped. Requests outside IDLE are ignored, never queued.
- Read path:
  - READ_ST0: latch req_addr into mem_addr.
  - READ_ST1: mem_cs=1.
  - READ_ST2: mem_cs=1, mem_oe=1; clear counter.
  - READ_WAIT: mem_cs=1, mem_oe=1.
    - mem_ack=1: rd_data<=mem_rdata, go to READ_DONE.
    - Otherwise, counter==TIMEOUT-1: err<=1, go to IDLE.
  - READ_DONE: bus idle; rd_data held; done_clr=1 -> IDLE. Requests here are ignored.
- Write path:
  - WRITE_ST0: latch req_addr into mem_addr and req_wdata into mem_wdata.
  - WRITE_ST1: mem_cs=1.
  - WRITE_ST2: mem_cs=1.
  - WRITE_ST3: mem_cs=1, mem_we=1.
  - WRITE_ST4: mem_cs=1, mem_we=1; clear counter.
  - WRITE_WAIT: mem_cs=1, mem_we=0.
    - mem_ack=1 -> IDLE.
    - Otherwise, counter==TIMEOUT-1: err<=1, go to IDLE.
- mem_ack is ignored outside the WAIT states.
- err clears only on a successful ack in either WAIT state or on reset.
- Any non-one-hot state value recovers to IDLE on the next edge with the bus idle.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path.

## Timing
- Request pulse at edge k is sampled in IDLE: state=READ_ST0/WRITE_ST0 after edge k; mem_addr is valid after edge k+1.
- Read with mem_ack high on the first READ_WAIT cycle:
  - 4 cycles from request sample to READ_DONE entry.
  - rd_data is valid in the same cycle state shows READ_DONE.
- Write with immediate ack: 6 cycles from request sample to return to IDLE; mem_we is high for exactly 2 cycles.
- Timeout: a WAIT state lasts exactly TIMEOUT cycles when ack never arrives.
- After rst_n deasserts: IDLE after exactly INIT_CYCLES edges.

## Test plan
- Reset: hold rst_n=0, release with INIT_CYCLES=16 -> state=13'h0001 for 16 cycles, then 13'h0002; all bus outputs, rd_data and err are 0 throughout.
- Read: req_addr=10'h05A, rd_req pulse, mem_ack after 3 WAIT cycles with mem_rdata=16'hBEEF:
  - state steps 0x0004, 0x0008, 0x0010, 0x0020 x3, 0x0040; rd_data=16'hBEEF.
  - done_clr pulse -> state returns to 0x0002.
- Write: req_addr=10'h3FF, req_wdata=16'h1234, wr_req pulse, immediate ack:
  - mem_we high only in WRITE_ST3/ST4; mem_addr=10'h3FF and mem_wdata=16'h1234 from WRITE_ST1 on.
  - IDLE after 6 cycles.
- Timeout: TIMEOUT=8, read with mem_ack tied 0 -> READ_WAIT exactly 8 cycles, then IDLE, err=1; a following successful write clears err.
- Simultaneous requests: rd_req and wr_req in the same IDLE cycle -> read sequence only; no mem_we pulse ever. Also: wr_req during READ_WAIT is ignored.
- Async reset asserted during WRITE_ST3 -> mem_we and mem_cs drop before the next clock edge; state=0x0001.
